// File: rtl/mux2_arb_pkg.sv
// Shared constants for the two-input stream arbiter: source encodings and FSM states.
// Source encoding matches the downstream 2-to-1 mux select (0 = A, 1 = B).
package mux2_arb_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage : mux2_arb_pkg

// File: rtl/mux2_rr_grant.sv
// Combinational two-way grant: round-robin by default, A-priority when
// MUX2_ARB_FIXED_PRIO_EN is defined.
module mux2_rr_grant
  import mux2_arb_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic sel,
  output logic grant_any
);

  always_comb begin
    sel       = last_grant;
    grant_any = a_valid | b_valid;
    if (a_valid && b_valid) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
      sel = SRC_A;
`else
      sel = ~last_grant;
`endif
    end else if (a_valid) begin
      sel = SRC_A;
    end else if (b_valid) begin
      sel = SRC_B;
    end
  end

endmodule : mux2_rr_grant

// File: rtl/mux2_stream_arb.sv
// Arbitrates two valid/ready streams into one registered output stream and drives
// the mux select. Optional A-priority arbitration via MUX2_ARB_FIXED_PRIO_EN.
module mux2_stream_arb
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  arb_state_e       state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_src_reg, out_src_next;

  logic             sel_w;
  logic             grant_any;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  mux2_rr_grant u_grant (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_grant_reg),
    .sel        (sel_w),
    .grant_any  (grant_any)
  );

  // Per-bit data steering mirrors the downstream single-bit mux.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_data_mux
      assign grant_data[gi] = (sel_w == SRC_B) ? b_data[gi] : a_data[gi];
    end
  endgenerate

  assign can_load = (state_reg == ST_EMPTY) || out_ready;
  assign load     = can_load && grant_any;

  // Readies are forced low while reset is asserted, independent of the clock.
  assign a_ready = rst_n && load && (sel_w == SRC_A) && a_valid;
  assign b_ready = rst_n && load && (sel_w == SRC_B) && b_valid;

  assign sel       = sel_w;
  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    out_data_next   = out_data_reg;
    out_src_next    = out_src_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (load) begin
          state_next      = ST_FULL;
          last_grant_next = sel_w;
          out_data_next   = grant_data;
          out_src_next    = sel_w;
        end
      end
      ST_FULL: begin
        // Drain and reload in one cycle keeps the stream bubble-free.
        if (load) begin
          last_grant_next = sel_w;
          out_data_next   = grant_data;
          out_src_next    = sel_w;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_EMPTY;
      last_grant_reg <= SRC_B;
      out_data_reg   <= '0;
      out_src_reg    <= SRC_A;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      out_data_reg   <= out_data_next;
      out_src_reg    <= out_src_next;
    end
  end

endmodule : mux2_stream_arb
